// File: rtl/ext_mem_pkg.sv
// Shared definitions for the ext_mem_io peripheral: register addresses,
// STATUS bit positions and the decoded register select.
package ext_mem_pkg;

    // Register word addresses on the external memory port
    localparam int ADDR_GPIO_OUT = 0;
    localparam int ADDR_GPIO_IN  = 1;
    localparam int ADDR_USEC_LO  = 2;
    localparam int ADDR_USEC_HI  = 3;
    localparam int ADDR_TIMER    = 4;
    localparam int ADDR_STATUS   = 5;

    // STATUS register bit positions
    localparam int STATUS_EXPIRED_BIT = 0;

    // Decoded register select; SEL_NONE covers every unmapped address
    typedef enum logic [2:0] {
        SEL_GPIO_OUT = 3'd0,
        SEL_GPIO_IN  = 3'd1,
        SEL_USEC_LO  = 3'd2,
        SEL_USEC_HI  = 3'd3,
        SEL_TIMER    = 3'd4,
        SEL_STATUS   = 3'd5,
        SEL_NONE     = 3'd7
    } reg_sel_e;

    // Map the low three address bits to a register select. Any address with
    // a nonzero bit above bit 2 falls outside the map.
    function automatic reg_sel_e decode_addr(input logic [2:0] low,
                                             input logic       upper_zero);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (upper_zero) begin
            case (low)
                3'd0:    sel = SEL_GPIO_OUT;
                3'd1:    sel = SEL_GPIO_IN;
                3'd2:    sel = SEL_USEC_LO;
                3'd3:    sel = SEL_USEC_HI;
                3'd4:    sel = SEL_TIMER;
                3'd5:    sel = SEL_STATUS;
                default: sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/usec_tick_gen.sv
// Microsecond prescaler: divides I_CLK down to a one-cycle tick that is high
// while the phase counter sits at its last value, i.e. once every
// P_CLK_CYCLES_PER_MICROSECOND cycles. The phase restarts at 0 on reset, so
// the first tick edge is exactly P cycles after reset is released.
module usec_tick_gen #(
    parameter int P_CLK_CYCLES_PER_MICROSECOND = 50
) (
    input  logic I_CLK,
    input  logic I_RESET,
    output logic O_TICK
);

    localparam int CNT_W = $clog2(P_CLK_CYCLES_PER_MICROSECOND);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(P_CLK_CYCLES_PER_MICROSECOND - 1);

    logic [CNT_W-1:0] count;

    // The tick is a pure decode of the registered phase count, so it is
    // glitch-free at the register boundary and exactly one cycle wide.
    assign O_TICK = (count == LAST);

    // Phase counter: 0 .. P-1, then wrap
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            count <= '0;
        end else if (O_TICK) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ext_mem_io.sv
// CR16 external-memory peripheral: open-drain GPIO with synchronised inputs,
// a free-running microsecond counter with a tear-free upper-half snapshot,
// and a one-shot microsecond countdown timer with a sticky expiry interrupt.
//
// Bus semantics: there is no handshake. Every cycle is a transfer. With
// I_EXT_MEM_WRITE_ENABLE=1 the addressed register takes I_EXT_MEM_DATA on
// that edge and O_EXT_MEM_DATA holds its previous value; with it at 0 the
// addressed register is captured into O_EXT_MEM_DATA on that edge, so read
// data is valid exactly one cycle after the address is presented.
module ext_mem_io
    import ext_mem_pkg::*;
#(
    parameter int P_DATA_WIDTH                 = 16,
    parameter int P_ADDRESS_WIDTH              = 3,
    parameter int P_GPIO_COUNT                 = 2,
    parameter int P_CLK_CYCLES_PER_MICROSECOND = 50
) (
    input  logic                       I_CLK,
    input  logic                       I_RESET,
    input  logic [P_DATA_WIDTH-1:0]    I_EXT_MEM_DATA,
    input  logic [P_ADDRESS_WIDTH-1:0] I_EXT_MEM_ADDRESS,
    input  logic                       I_EXT_MEM_WRITE_ENABLE,
    output logic [P_DATA_WIDTH-1:0]    O_EXT_MEM_DATA,
    input  logic [P_GPIO_COUNT-1:0]    I_GPIO_IN,
    output logic [P_GPIO_COUNT-1:0]    O_GPIO_DRIVE_LOW,
    output logic                       O_TIMER_IRQ
);

    localparam int W  = P_DATA_WIDTH;
    localparam int CW = 2 * P_DATA_WIDTH;
    localparam int G  = P_GPIO_COUNT;

    // ------------------------------------------------------------------
    // Microsecond tick
    // ------------------------------------------------------------------
    logic tick;

    usec_tick_gen #(
        .P_CLK_CYCLES_PER_MICROSECOND(P_CLK_CYCLES_PER_MICROSECOND)
    ) u_tick (
        .I_CLK  (I_CLK),
        .I_RESET(I_RESET),
        .O_TICK (tick)
    );

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic     upper_zero;
    reg_sel_e sel;

    if (P_ADDRESS_WIDTH > 3) begin : g_upper
        assign upper_zero = ~|I_EXT_MEM_ADDRESS[P_ADDRESS_WIDTH-1:3];
    end else begin : g_no_upper
        assign upper_zero = 1'b1;
    end

    assign sel = decode_addr(I_EXT_MEM_ADDRESS[2:0], upper_zero);

    logic rd_en;
    logic wr_gpio;
    logic wr_timer;
    logic wr_status;
    logic rd_usec_lo;

    assign rd_en      = ~I_EXT_MEM_WRITE_ENABLE;
    assign wr_gpio    = I_EXT_MEM_WRITE_ENABLE & (sel == SEL_GPIO_OUT);
    assign wr_timer   = I_EXT_MEM_WRITE_ENABLE & (sel == SEL_TIMER);
    assign wr_status  = I_EXT_MEM_WRITE_ENABLE & (sel == SEL_STATUS);
    assign rd_usec_lo = rd_en & (sel == SEL_USEC_LO);

    // ------------------------------------------------------------------
    // GPIO: release register and registered open-drain drive
    // ------------------------------------------------------------------
    logic [G-1:0] gpio_release;
    logic [G-1:0] drive_low;

    // Release register takes writes; the pad drive follows one cycle later
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            gpio_release <= '1;
            drive_low    <= '0;
        end else begin
            if (wr_gpio) begin
                gpio_release <= I_EXT_MEM_DATA[G-1:0];
            end
            drive_low <= ~gpio_release;
        end
    end

    assign O_GPIO_DRIVE_LOW = drive_low;

    // ------------------------------------------------------------------
    // GPIO input synchroniser (pads are asynchronous to I_CLK)
    // ------------------------------------------------------------------
    logic [G-1:0] gpio_sync1;
    logic [G-1:0] gpio_sync2;

    // Two-flop synchroniser for the raw pad levels
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            gpio_sync1 <= '0;
            gpio_sync2 <= '0;
        end else begin
            gpio_sync1 <= I_GPIO_IN;
            gpio_sync2 <= gpio_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Microsecond counter and upper-half snapshot
    // ------------------------------------------------------------------
    logic [CW-1:0] usec;
    logic [W-1:0]  usec_shadow;

    // Counter advances on each tick; a USEC_LO read latches the upper half
    // from the same pre-increment value the read returns, so a LO-then-HI
    // read pair never tears across a carry.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            usec        <= '0;
            usec_shadow <= '0;
        end else begin
            if (tick) begin
                usec <= usec + CW'(1);
            end
            if (rd_usec_lo) begin
                usec_shadow <= usec[CW-1:W];
            end
        end
    end

    // ------------------------------------------------------------------
    // One-shot countdown timer and sticky expiry flag
    // ------------------------------------------------------------------
    logic [W-1:0] timer;
    logic         expired;
    logic         expire_evt;

    // A write on the tick edge takes priority, so only an unwritten 1->0
    // decrement counts as an expiry.
    assign expire_evt = tick & ~wr_timer & (timer == W'(1));

    // Countdown: load on write, decrement on tick while nonzero, hold at 0
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            timer <= '0;
        end else if (wr_timer) begin
            timer <= I_EXT_MEM_DATA;
        end else if (tick && (timer != '0)) begin
            timer <= timer - W'(1);
        end
    end

    // Sticky expiry flag: set beats a same-edge write-one-to-clear
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            expired <= 1'b0;
        end else if (expire_evt) begin
            expired <= 1'b1;
        end else if (wr_status && I_EXT_MEM_DATA[STATUS_EXPIRED_BIT]) begin
            expired <= 1'b0;
        end
    end

    assign O_TIMER_IRQ = expired;

    // ------------------------------------------------------------------
    // Read mux and registered read data
    // ------------------------------------------------------------------
    logic [W-1:0] rd_value;

    // Select the addressed register; unmapped addresses and unused bits read 0
    always_comb begin
        rd_value = '0;
        case (sel)
            SEL_GPIO_OUT: rd_value[G-1:0] = gpio_release;
            SEL_GPIO_IN:  rd_value[G-1:0] = gpio_sync2;
            SEL_USEC_LO:  rd_value        = usec[W-1:0];
            SEL_USEC_HI:  rd_value        = usec_shadow;
            SEL_TIMER:    rd_value        = timer;
            SEL_STATUS:   rd_value[STATUS_EXPIRED_BIT] = expired;
            default:      rd_value        = '0;
        endcase
    end

    // Read data register: updates on read cycles, holds through writes
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            O_EXT_MEM_DATA <= '0;
        end else if (rd_en) begin
            O_EXT_MEM_DATA <= rd_value;
        end
    end

endmodule

// File: tb/tb_ext_mem_io.sv
// Self-checking bench for ext_mem_io. A default-sized instance (W=16, 50
// cycles per microsecond) covers GPIO, timer, STATUS and reset behaviour; a
// small instance (W=8, 2 cycles per microsecond) reaches the counter carry
// from 0x00FF to 0x0100 quickly to exercise the snapshot rules.
module tb_ext_mem_io;

  localparam int W  = 16;
  localparam int G  = 2;
  localparam int P  = 50;
  localparam int SW = 8;
  localparam int SP = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst = 1'b1;
  int   cyc = 0;
  int   base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance bus
  logic [W-1:0] wdata = '0;
  logic [2:0]   addr = 3'd7;
  logic         we = 1'b0;
  logic [W-1:0] rdata;
  logic [G-1:0] gpio_in = '0;
  logic [G-1:0] drive_low;
  logic         irq;

  // small instance bus
  logic [SW-1:0] s_wdata = '0;
  logic [2:0]    s_addr = 3'd7;
  logic          s_we = 1'b0;
  logic [SW-1:0] s_rdata;
  logic [G-1:0]  s_gpio_in = '0;
  logic [G-1:0]  s_drive_low;
  logic          s_irq;

  ext_mem_io #(
    .P_DATA_WIDTH(W), .P_ADDRESS_WIDTH(3), .P_GPIO_COUNT(G),
    .P_CLK_CYCLES_PER_MICROSECOND(P)
  ) dut (
    .I_CLK(clk), .I_RESET(rst),
    .I_EXT_MEM_DATA(wdata), .I_EXT_MEM_ADDRESS(addr),
    .I_EXT_MEM_WRITE_ENABLE(we), .O_EXT_MEM_DATA(rdata),
    .I_GPIO_IN(gpio_in), .O_GPIO_DRIVE_LOW(drive_low), .O_TIMER_IRQ(irq)
  );

  ext_mem_io #(
    .P_DATA_WIDTH(SW), .P_ADDRESS_WIDTH(3), .P_GPIO_COUNT(G),
    .P_CLK_CYCLES_PER_MICROSECOND(SP)
  ) dut_small (
    .I_CLK(clk), .I_RESET(rst),
    .I_EXT_MEM_DATA(s_wdata), .I_EXT_MEM_ADDRESS(s_addr),
    .I_EXT_MEM_WRITE_ENABLE(s_we), .O_EXT_MEM_DATA(s_rdata),
    .I_GPIO_IN(s_gpio_in), .O_GPIO_DRIVE_LOW(s_drive_low), .O_TIMER_IRQ(s_irq)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic [SW-1:0] exp_s_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input int a, input logic [W-1:0] d);
    addr  = 3'(a);
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
    addr  = 3'd7;
  endtask

  task automatic bus_read(input int a, input logic [W-1:0] e, input string tag);
    addr = 3'(a);
    we   = 1'b0;
    exp_q.push_back(e);
    step();
    addr = 3'd7;
    check(tag, rdata, exp_q.pop_front());
  endtask

  task automatic s_read(input int a, input logic [SW-1:0] e, input string tag);
    s_addr = 3'(a);
    s_we   = 1'b0;
    exp_s_q.push_back(e);
    step();
    s_addr = 3'd7;
    check(tag, s_rdata, exp_s_q.pop_front());
  endtask

  // Main instance ticks on edges base+P, base+2P, ...
  function automatic bit next_is_tick();
    return ((cyc + 1 - base) % P) == 0;
  endfunction

  // Advance until just past the next main-instance tick edge
  task automatic wait_tick();
    while (!next_is_tick()) step();
    step();
  endtask

  // Watchdog: the run is a few thousand cycles; anything far beyond is a hang
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [SW-1:0] lo_exp;

    rst = 1'b1;
    repeat (3) step();
    rst  = 1'b0;
    base = cyc;

    // Reset state
    check("rst_rdata", rdata, 0);
    check("rst_drive_low", drive_low, 0);
    check("rst_irq", irq, 0);
    bus_read(1, 16'h0000, "rst_gpio_in");
    bus_read(5, 16'h0000, "rst_status");
    bus_read(0, 16'h0003, "rst_gpio_out");

    // Read data holds through a write; drive follows one cycle later
    bus_write(0, 16'h0002);
    check("rdata_hold_on_write", rdata, 16'h0003);
    check("drive_low_not_yet", drive_low, 2'b00);
    step();
    check("drive_low_after", drive_low, 2'b01);
    bus_read(0, 16'h0002, "gpio_out_rb");

    // Upper bits of GPIO_OUT ignored
    bus_write(0, 16'hFFFD);
    bus_read(0, 16'h0001, "gpio_out_upper");
    check("drive_low_10", drive_low, 2'b10);
    bus_write(0, 16'hFFFF);
    step();
    check("drive_low_rel", drive_low, 2'b00);

    // Unmapped address: writes ignored, reads 0
    bus_write(6, 16'hFFFF);
    bus_read(6, 16'h0000, "unmapped_6");
    bus_read(7, 16'h0000, "unmapped_7");

    // Input synchroniser latency
    gpio_in = 2'b10;
    bus_read(1, 16'h0000, "gpio_in_c1");
    addr = 3'd1;
    step();
    bus_read(1, 16'h0002, "gpio_in_c3");

    // Timer countdown 3,2,1,0 and expiry
    wait_tick();
    bus_write(4, 16'd3);
    bus_read(4, 16'd3, "timer_3");
    wait_tick();
    bus_read(4, 16'd2, "timer_2");
    wait_tick();
    bus_read(4, 16'd1, "timer_1");
    check("irq_before_expiry", irq, 0);
    wait_tick();
    bus_read(4, 16'd0, "timer_0");
    bus_read(5, 16'h0001, "status_expired");
    check("irq_expired", irq, 1);
    bus_write(5, 16'h0001);
    check("irq_cleared", irq, 0);
    bus_read(5, 16'h0000, "status_cleared");
    wait_tick();
    bus_read(4, 16'd0, "timer_stays_0");

    // Write on a tick edge is not decremented that cycle
    while (!next_is_tick()) step();
    bus_write(4, 16'd5);
    bus_read(4, 16'd5, "timer_load_on_tick");
    wait_tick();
    bus_read(4, 16'd4, "timer_4");

    // Writing 0 stops a running timer without expiry
    bus_write(4, 16'd0);
    bus_read(4, 16'd0, "timer_stopped");
    repeat (6) wait_tick();
    bus_read(5, 16'h0000, "status_no_expiry");
    check("irq_no_expiry", irq, 0);

    // Expiry and W1C on the same edge: set wins
    wait_tick();
    bus_write(4, 16'd1);
    while (!next_is_tick()) step();
    bus_write(5, 16'h0001);
    check("irq_set_wins", irq, 1);
    bus_read(5, 16'h0001, "status_set_wins");
    bus_write(5, 16'h0000);
    bus_read(5, 16'h0001, "status_w0_no_clear");
    bus_write(5, 16'h0001);
    bus_read(5, 16'h0000, "status_w1c");

    // Reset mid-countdown with GPIO driven low, colliding with a write
    bus_write(0, 16'h0000);
    step();
    check("drive_low_all", drive_low, 2'b11);
    bus_write(4, 16'd10);
    wait_tick();
    bus_read(4, 16'd9, "timer_pre_reset");
    rst   = 1'b1;
    addr  = 3'd0;
    we    = 1'b1;
    wdata = 16'h0000;
    step();
    rst  = 1'b0;
    we   = 1'b0;
    addr = 3'd7;
    base = cyc;
    check("rst2_rdata", rdata, 0);
    check("rst2_drive_low", drive_low, 2'b00);
    check("rst2_irq", irq, 0);
    bus_read(1, 16'h0000, "rst2_gpio_in_sync");
    bus_read(0, 16'h0003, "rst2_gpio_out");
    bus_read(4, 16'h0000, "rst2_timer");
    bus_read(5, 16'h0000, "rst2_status");
    bus_read(3, 16'h0000, "rst2_usec_hi");

    // First tick lands exactly P edges after reset release
    while ((cyc + 1 - base) < P - 1) step();
    bus_read(2, 16'h0000, "usec_before_tick");
    bus_read(2, 16'h0000, "usec_on_tick");
    bus_read(2, 16'h0001, "usec_after_tick");

    // Small instance: carry from 0x00FF to 0x0100, tick every SP edges
    while ((cyc + 1 - base) < 256 * SP) step();
    s_read(2, 8'hFF, "snap_lo_on_tick");
    s_read(3, 8'h00, "snap_hi_pre_carry");
    repeat (10) step();
    s_read(3, 8'h00, "snap_hi_held");
    lo_exp = SW'((cyc - base) / SP);
    s_read(2, lo_exp, "snap_lo_after");
    s_read(3, 8'h01, "snap_hi_new");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ext_mem_io.md
Name: ext_mem_io

Overview:
- Parametrised successor to the CR16 external-memory peripheral map; sits between the CR16 external memory port and board I/O.
- Provides N open-drain GPIO lines (I2C SCL/SDA-style bit-bang) with synchronised inputs.
- Provides a free-running microsecond counter with a tear-free upper-half snapshot.
- Provides a microsecond one-shot countdown timer with a sticky expiry flag and interrupt output.

Parameters:
- P_DATA_WIDTH, 16, data bus width W; counter width is 2*W.
- P_ADDRESS_WIDTH, 3, address width; must be at least 3.
- P_GPIO_COUNT, 2, number of open-drain lines; must satisfy 1 <= P_GPIO_COUNT <= P_DATA_WIDTH.
- P_CLK_CYCLES_PER_MICROSECOND, 50, I_CLK cycles per microsecond tick; must be at least 2.

Ports:
- I_CLK  in  1  system clock (50 MHz).
- I_RESET  in  1  synchronous, active-high reset.
- I_EXT_MEM_DATA  in  P_DATA_WIDTH  write data.
- I_EXT_MEM_ADDRESS  in  P_ADDRESS_WIDTH  register address.
- I_EXT_MEM_WRITE_ENABLE  in  1  1 = write, 0 = read.
- O_EXT_MEM_DATA  out  P_DATA_WIDTH  registered read data.
- I_GPIO_IN  in  P_GPIO_COUNT  raw pad levels (asynchronous).
- O_GPIO_DRIVE_LOW  out  P_GPIO_COUNT  1 = pull pad low, 0 = release (high-Z); the tristate buffer lives at top level.
- O_TIMER_IRQ  out  1  level, equals the sticky expiry flag.

Behaviour:
- Clock and reset: one clock, I_CLK. Reset is synchronous and active-high on I_RESET. All state updates on the posedge.
- Reset values: O_EXT_MEM_DATA=0; GPIO release register all 1s, so O_GPIO_DRIVE_LOW=0; synchronisers 0; prescaler 0; usec counter 0; shadow 0; timer 0; expired flag 0; O_TIMER_IRQ=0.
- Register map (R = read, W = write):
  - 0 GPIO_OUT R/W: bit i=1 releases line i, 0 drives it low. O_GPIO_DRIVE_LOW = ~reg. Unused upper bits read 0, writes to them are ignored.
  - 1 GPIO_IN R: 2-flop synchronised I_GPIO_IN, zero-extended. Writes ignored.
  - 2 USEC_LO R: lower W bits of the counter. The same edge copies the upper W bits into the shadow register.
  - 3 USEC_HI R: returns the shadow register, not the live upper half.
  - 4 TIMER R/W: write N loads the countdown. Read returns the remaining microseconds.
  - 5 STATUS R/W1C: bit0 = expired. Writing 1 to bit0 clears it; other bits read 0.
  - 6 and 7: unmapped. Reads return 0, writes ignored.
- Read latency: exactly 1 cycle. O_EXT_MEM_DATA is registered from the address present with WE=0. During a write cycle O_EXT_MEM_DATA holds its previous value.
- Write timing: the written value is visible at the register output on the edge where WE=1. A GPIO_OUT write reaches O_GPIO_DRIVE_LOW 1 cycle later.
- Prescaler:
  - Counts 0..P_CLK_CYCLES_PER_MICROSECOND-1 and wraps.
  - The tick pulse is 1 cycle wide, asserted when count == P-1.
  - The usec counter increments on each tick and wraps from 2^(2W)-1 to 0.
- Snapshot rules:
  - If a USEC_LO read coincides with a tick, both the read data and the shadow take the pre-increment value.
  - The shadow changes only on USEC_LO reads.
- Timer:
  - Write N>0 loads N. Each tick decrements it while it is nonzero.
  - The transition 1→0 sets expired.
  - Write 0 stops the timer without setting expired.
  - A write coinciding with a tick wins: the loaded value is not decremented that cycle.
  - The timer is one-shot and stays at 0 after expiry.
- STATUS set/clear collision: if the expiry event and a W1C clear of STATUS happen on the same edge, set wins and expired stays 1.
- Reset mid-operation: I_RESET has priority over every write or tick on the same edge and restores all reset values. Tick phase restarts at 0.

Decomposition:
- Package ext_mem_pkg holds:
  - the register address localparams (ADDR_GPIO_OUT=0 … ADDR_STATUS=5);
  - the STATUS bit index constant (STATUS_EXPIRED_BIT=0);
  - a typedef enum for the register select.
- One sub-module, usec_tick_gen:
  - prescaler only;
  - parameter P_CLK_CYCLES_PER_MICROSECOND;
  - ports I_CLK, I_RESET, O_TICK.
- ext_mem_io contains the register file, counter, shadow, timer and read mux.

Test Plan:
- Reset, then release; read addresses 0,1,5 → 0x0003 (P_GPIO_COUNT=2), 0x0000, 0x0000; O_GPIO_DRIVE_LOW=2'b00; O_TIMER_IRQ=0.
- Write 0x0002 to addr 0 → O_GPIO_DRIVE_LOW=2'b01 one cycle later. Drive I_GPIO_IN=2'b10 → addr 1 reads 0x0002 by the 3rd cycle after the change, and not earlier than the 2nd.
- Force the counter near wrap: run until USEC=0x0000FFFF, read addr 2 on the tick edge → returns 0xFFFF. A following addr 3 read returns 0x0000, not 0x0001, even after 0x00010000 is reached.
- Write 3 to addr 4 → addr 4 reads 3,2,1,0 at successive ticks (50 cycles apart). STATUS reads 0x0001 and O_TIMER_IRQ=1 after the 3rd tick. Write 0x0001 to addr 5 → IRQ deasserts next cycle.
- Collisions:
  - Write 5 to addr 4 on a tick edge → next read returns 5.
  - W1C on STATUS in the same cycle as expiry → STATUS stays 0x0001.
  - Write 0 to a running timer → no expiry.
- Assert I_RESET for 1 cycle mid-countdown with GPIO driven low → all registers read reset values. First tick arrives exactly 50 cycles after reset deasserts.
